button_event_arbiter: RTL and testbench
=======================================

Name: button_event_arbiter

Overview:
- Collects debounced press/release pulses from N_CH button channels, each driven by a debounced edge-detect front end with one-cycle positive/negative edge pulses.
- Buffers one pending event per channel and serialises them through a round-robin arbiter onto a single valid/ready event stream for a downstream consumer (UI FSM, register block).
- Flags lost events per channel with sticky overflow bits.

Parameters:
- N_CH, 4, number of button channels (2..16).
- ID_W, 2, width of ev_id; must satisfy 2**ID_W >= N_CH.

Ports:
- clk  input  1  system clock (50 MHz).
- reset_b  input  1  asynchronous active-low reset; all state cleared while low.
- pos_pulse  input  N_CH  per-channel one-cycle press (positive edge) pulse.
- neg_pulse  input  N_CH  per-channel one-cycle release (negative edge) pulse.
- ev_valid  output  1  event available on ev_id/ev_type.
- ev_ready  input  1  consumer accepts event when ev_valid && ev_ready at a rising edge.
- ev_id  output  ID_W  channel index of the presented event.
- ev_type  output  1  1 = press, 0 = release.
- overflow  output  N_CH  sticky per-channel lost-event flags.
- ovf_clear  input  N_CH  per-bit clear of overflow, sampled each edge.
- pending  output  N_CH  per-channel pending-slot occupancy, for status and debug.

Behaviour:
- Reset values:
  - ev_valid=0, ev_id=0, ev_type=0, overflow=0, pending=0.
  - Round-robin pointer last=N_CH-1, so channel 0 has first priority after reset.
- Reset mid-operation discards all pending and presented events; no event is presented after reset deasserts until a new pulse arrives.
- Per-channel pending slot: pend[i] (1 bit) plus ptype[i] (1 bit).
- Capture at each edge, per channel i:
  - pos_pulse[i] or neg_pulse[i] with slot free, or slot being loaded to output this same edge: set pend[i]. ptype[i]=1 if pos_pulse[i], else 0.
  - Pulse with slot occupied and not being loaded this edge: event dropped, overflow[i] set, existing slot unchanged.
  - pos_pulse[i] and neg_pulse[i] in the same cycle: capture press, set overflow[i].
- Output register (one entry):
  - free = !ev_valid || ev_ready.
  - If free and any pend set: load the winning channel. ev_valid=1, ev_id=winner, ev_type=ptype[winner]. Clear pend[winner] (unless a new pulse recaptures it per the capture rule). last=winner.
  - If free and no pend: ev_valid=0; ev_id and ev_type hold their previous values.
  - If ev_valid && !ev_ready: ev_valid, ev_id and ev_type hold stable; no pend is cleared.
- Arbitration:
  - Round-robin search order last+1, last+2, ... wrapping modulo N_CH.
  - Winner is the first set pend.
  - Each channel waits at most N_CH-1 grants.
- Latency: pulse sampled at edge k sets pend at k. Earliest ev_valid=1 is after edge k+1.
- Throughput: one event per cycle when ev_ready is held high.
- Overflow clear:
  - ovf_clear[i] clears overflow[i].
  - If an overflow condition occurs on the same edge, set wins and the bit stays 1.
- pending output = pend register, combinational from the flops; no extra latency.
- Per-channel order: at most one event in the output register plus one pending, so press/release order per channel is preserved.

Test Plan:
- Reset, single event: pos_pulse[2] one cycle at edge k, ev_ready=1 -> ev_valid=1 after k+1 with ev_id=2, ev_type=1, held one cycle; pending[2]=0 after k+1.
- Simultaneous: pos_pulse=4'b1111 one cycle, ev_ready=1 -> four consecutive beats with ev_id 0,1,2,3. A further burst 4'b1001 then yields ids 0,3.
- Backpressure: ev_ready=0 with an event on channel 1 -> ev_valid, ev_id and ev_type stable for 20 cycles. Raising ev_ready gives acceptance on the first edge.
- Overflow: ev_ready=0. pos_pulse[0], neg_pulse[0], then pos_pulse[0] again -> first event presented, release pending, third pulse dropped, overflow[0]=1. After ev_ready=1, output is press then release. ovf_clear[0] -> overflow[0]=0.
- Same-cycle recapture: channel 3 pending and granted on the same edge as a new neg_pulse[3] -> pend[3] stays 1 with ptype=0, overflow[3]=0.
- Reset mid-stream: with 3 events pending and ev_valid=1, pulse reset_b low for 1 cycle -> all outputs 0 immediately (async), no events emitted afterward.

Source files
------------

// File: rtl/button_event_arbiter.sv
// Serialises per-channel press/release pulses onto one valid/ready stream.
// Each channel keeps one pending event; a round-robin arbiter picks the next channel to present.

module button_event_arbiter_slot (
  input  logic clk,
  input  logic reset_b,
  input  logic pos,
  input  logic neg,
  input  logic grant,
  input  logic ovf_clr,
  output logic pend,
  output logic ptype,
  output logic ovf
);
  logic pulse, busy, ovf_set;

  assign pulse   = pos | neg;
  // A slot that is being granted this edge is free to take a new pulse.
  assign busy    = pend & ~grant;
  assign ovf_set = (pulse & busy) | (pos & neg);

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      pend  <= 1'b0;
      ptype <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      if (pulse && !busy) begin
        pend  <= 1'b1;
        ptype <= pos;
      end else if (grant) begin
        pend  <= 1'b0;
      end
      ovf <= ovf_set | (ovf & ~ovf_clr);
    end
  end
endmodule

module button_event_arbiter #(
  parameter int N_CH = 4,
  parameter int ID_W = 2
) (
  input  logic            clk,
  input  logic            reset_b,
  input  logic [N_CH-1:0] pos_pulse,
  input  logic [N_CH-1:0] neg_pulse,
  output logic            ev_valid,
  input  logic            ev_ready,
  output logic [ID_W-1:0] ev_id,
  output logic            ev_type,
  output logic [N_CH-1:0] overflow,
  input  logic [N_CH-1:0] ovf_clear,
  output logic [N_CH-1:0] pending
);
  logic [N_CH-1:0] pend, ptype, grant;
  logic [ID_W-1:0] last, win_id;
  logic            found, free;

  assign free    = ~ev_valid | ev_ready;
  assign pending = pend;

  // Search starts one past the last winner so every channel waits at most N_CH-1 grants.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    for (int k = 1; k <= N_CH; k++) begin
      int idx;
      idx = (int'(last) + k) % N_CH;
      if (!found && pend[idx]) begin
        found  = 1'b1;
        win_id = ID_W'(idx);
      end
    end
  end

  always_comb begin
    grant = '0;
    if (free && found) grant[win_id] = 1'b1;
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_slot
    button_event_arbiter_slot u_slot (
      .clk     (clk),
      .reset_b (reset_b),
      .pos     (pos_pulse[i]),
      .neg     (neg_pulse[i]),
      .grant   (grant[i]),
      .ovf_clr (ovf_clear[i]),
      .pend    (pend[i]),
      .ptype   (ptype[i]),
      .ovf     (overflow[i])
    );
  end

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      ev_valid <= 1'b0;
      ev_id    <= '0;
      ev_type  <= 1'b0;
      last     <= ID_W'(N_CH - 1);
    end else if (free) begin
      ev_valid <= found;
      if (found) begin
        ev_id   <= win_id;
        ev_type <= ptype[win_id];
        last    <= win_id;
      end
    end
  end
endmodule

// File: tb/tb_button_event_arbiter.sv
// Directed bench for button_event_arbiter; expected values worked out by hand per scenario.

module tb_button_event_arbiter;
  logic       clk = 1'b0;
  logic       reset_b;
  logic [3:0] pos_pulse, neg_pulse, ovf_clear;
  logic       ev_valid, ev_ready, ev_type;
  logic [1:0] ev_id;
  logic [3:0] overflow, pending;
  int total = 0;
  int bad   = 0;

  button_event_arbiter #(.N_CH(4), .ID_W(2)) dut (
    .clk       (clk),
    .reset_b   (reset_b),
    .pos_pulse (pos_pulse),
    .neg_pulse (neg_pulse),
    .ev_valid  (ev_valid),
    .ev_ready  (ev_ready),
    .ev_id     (ev_id),
    .ev_type   (ev_type),
    .overflow  (overflow),
    .ovf_clear (ovf_clear),
    .pending   (pending)
  );

  always #5 clk = ~clk;

  // Observation point is 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_b = 1'b0;
    tick();
    reset_b = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    tick();
    total++;
    if ({ev_valid, ev_id, ev_type, pending, overflow} !== 12'h000) begin
      bad++;
      $display("FAIL reset_held got=%h exp=000", {ev_valid, ev_id, ev_type, pending, overflow});
    end
    reset_b = 1'b1;
    tick();
    total++;
    if ({ev_valid, ev_id, ev_type, pending, overflow} !== 12'h000) begin
      bad++;
      $display("FAIL reset_released got=%h exp=000", {ev_valid, ev_id, ev_type, pending, overflow});
    end
  endtask

  task automatic test_single();
    logic [11:0] exp [3];
    exp[0] = {1'b0, 2'd0, 1'b0, 4'b0100, 4'b0000};
    exp[1] = {1'b1, 2'd2, 1'b1, 4'b0000, 4'b0000};
    exp[2] = {1'b0, 2'd2, 1'b1, 4'b0000, 4'b0000};
    ev_ready  = 1'b1;
    pos_pulse = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      pos_pulse = 4'b0000;
      total++;
      if ({ev_valid, ev_id, ev_type, pending, overflow} !== exp[i]) begin
        bad++;
        $display("FAIL single_%0d got=%h exp=%h", i, {ev_valid, ev_id, ev_type, pending, overflow}, exp[i]);
      end
    end
  endtask

  task automatic test_simultaneous();
    logic [11:0] exp [10];
    do_reset();
    exp[0] = {1'b0, 2'd0, 1'b0, 4'b1111, 4'b0000};
    exp[1] = {1'b1, 2'd0, 1'b1, 4'b1110, 4'b0000};
    exp[2] = {1'b1, 2'd1, 1'b1, 4'b1100, 4'b0000};
    exp[3] = {1'b1, 2'd2, 1'b1, 4'b1000, 4'b0000};
    exp[4] = {1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000};
    exp[5] = {1'b0, 2'd3, 1'b1, 4'b0000, 4'b0000};
    exp[6] = {1'b0, 2'd3, 1'b1, 4'b1001, 4'b0000};
    exp[7] = {1'b1, 2'd0, 1'b1, 4'b1000, 4'b0000};
    exp[8] = {1'b1, 2'd3, 1'b1, 4'b0000, 4'b0000};
    exp[9] = {1'b0, 2'd3, 1'b1, 4'b0000, 4'b0000};
    ev_ready  = 1'b1;
    pos_pulse = 4'b1111;
    for (int i = 0; i < 10; i++) begin
      tick();
      pos_pulse = (i == 5) ? 4'b1001 : 4'b0000;
      total++;
      if ({ev_valid, ev_id, ev_type, pending, overflow} !== exp[i]) begin
        bad++;
        $display("FAIL simul_%0d got=%h exp=%h", i, {ev_valid, ev_id, ev_type, pending, overflow}, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    ev_ready  = 1'b0;
    neg_pulse = 4'b0010;
    tick();
    neg_pulse = 4'b0000;
    total++;
    if ({ev_valid, pending} !== {1'b0, 4'b0010}) begin
      bad++;
      $display("FAIL bp_capture got=%b exp=00010", {ev_valid, pending});
    end
    for (int i = 0; i < 21; i++) begin
      tick();
      total++;
      if ({ev_valid, ev_id, ev_type, pending, overflow} !== {1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000}) begin
        bad++;
        $display("FAIL bp_hold_%0d got=%h exp=%h", i, {ev_valid, ev_id, ev_type, pending, overflow},
                 {1'b1, 2'd1, 1'b0, 4'b0000, 4'b0000});
      end
    end
    ev_ready = 1'b1;
    tick();
    total++;
    if ({ev_valid, ev_id, ev_type} !== {1'b0, 2'd1, 1'b0}) begin
      bad++;
      $display("FAIL bp_accept got=%b exp=0010", {ev_valid, ev_id, ev_type});
    end
  endtask

  task automatic test_overflow();
    logic [11:0] exp [8];
    logic [3:0]  pv [8];
    logic [3:0]  nv [8];
    logic [3:0]  cv [8];
    logic        rv [8];
    // Stimulus applied before each edge, and state expected just after it.
    pv[0] = 4'b0001; nv[0] = 4'b0000; cv[0] = 4'b0000; rv[0] = 1'b0; exp[0] = {1'b0, 2'd1, 1'b0, 4'b0001, 4'b0000};
    pv[1] = 4'b0000; nv[1] = 4'b0001; cv[1] = 4'b0000; rv[1] = 1'b0; exp[1] = {1'b1, 2'd0, 1'b1, 4'b0001, 4'b0000};
    pv[2] = 4'b0001; nv[2] = 4'b0000; cv[2] = 4'b0000; rv[2] = 1'b0; exp[2] = {1'b1, 2'd0, 1'b1, 4'b0001, 4'b0001};
    pv[3] = 4'b0000; nv[3] = 4'b0000; cv[3] = 4'b0000; rv[3] = 1'b1; exp[3] = {1'b1, 2'd0, 1'b0, 4'b0000, 4'b0001};
    pv[4] = 4'b0000; nv[4] = 4'b0000; cv[4] = 4'b0000; rv[4] = 1'b1; exp[4] = {1'b0, 2'd0, 1'b0, 4'b0000, 4'b0001};
    // Clear and a same-cycle press+release overflow: set wins.
    pv[5] = 4'b0001; nv[5] = 4'b0001; cv[5] = 4'b0001; rv[5] = 1'b1; exp[5] = {1'b0, 2'd0, 1'b0, 4'b0001, 4'b0001};
    pv[6] = 4'b0000; nv[6] = 4'b0000; cv[6] = 4'b0001; rv[6] = 1'b1; exp[6] = {1'b1, 2'd0, 1'b1, 4'b0000, 4'b0000};
    pv[7] = 4'b0000; nv[7] = 4'b0000; cv[7] = 4'b0000; rv[7] = 1'b1; exp[7] = {1'b0, 2'd0, 1'b1, 4'b0000, 4'b0000};
    for (int i = 0; i < 8; i++) begin
      pos_pulse = pv[i];
      neg_pulse = nv[i];
      ovf_clear = cv[i];
      ev_ready  = rv[i];
      tick();
      total++;
      if ({ev_valid, ev_id, ev_type, pending, overflow} !== exp[i]) begin
        bad++;
        $display("FAIL ovf_%0d got=%h exp=%h", i, {ev_valid, ev_id, ev_type, pending, overflow}, exp[i]);
      end
    end
  endtask

  task automatic test_recapture();
    logic [11:0] exp [4];
    exp[0] = {1'b0, 2'd0, 1'b1, 4'b1000, 4'b0000};
    exp[1] = {1'b1, 2'd3, 1'b1, 4'b1000, 4'b0000};
    exp[2] = {1'b1, 2'd3, 1'b0, 4'b0000, 4'b0000};
    exp[3] = {1'b0, 2'd3, 1'b0, 4'b0000, 4'b0000};
    ev_ready  = 1'b1;
    pos_pulse = 4'b1000;
    for (int i = 0; i < 4; i++) begin
      tick();
      pos_pulse = 4'b0000;
      neg_pulse = (i == 0) ? 4'b1000 : 4'b0000;
      total++;
      if ({ev_valid, ev_id, ev_type, pending, overflow} !== exp[i]) begin
        bad++;
        $display("FAIL recap_%0d got=%h exp=%h", i, {ev_valid, ev_id, ev_type, pending, overflow}, exp[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    ev_ready  = 1'b0;
    pos_pulse = 4'b1111;
    tick();
    pos_pulse = 4'b0000;
    tick();
    total++;
    if ({ev_valid, ev_id, ev_type, pending} !== {1'b1, 2'd0, 1'b1, 4'b1110}) begin
      bad++;
      $display("FAIL mid_setup got=%h exp=%h", {ev_valid, ev_id, ev_type, pending}, {1'b1, 2'd0, 1'b1, 4'b1110});
    end
    reset_b = 1'b0;
    #1;
    total++;
    if ({ev_valid, ev_id, ev_type, pending, overflow} !== 12'h000) begin
      bad++;
      $display("FAIL mid_async got=%h exp=000", {ev_valid, ev_id, ev_type, pending, overflow});
    end
    tick();
    reset_b  = 1'b1;
    ev_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++;
      if ({ev_valid, ev_id, ev_type, pending, overflow} !== 12'h000) begin
        bad++;
        $display("FAIL mid_after_%0d got=%h exp=000", i, {ev_valid, ev_id, ev_type, pending, overflow});
      end
    end
  endtask

  initial begin
    reset_b   = 1'b0;
    pos_pulse = '0;
    neg_pulse = '0;
    ovf_clear = '0;
    ev_ready  = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_backpressure();
    test_overflow();
    test_recapture();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
